// File: rtl/dmem_responder.sv
// Word-addressed data memory behind valid/ready request and response channels.
// One outstanding request, with a fixed number of wait states between accept and response.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned OFS_W = 33;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   req_t               cap;
   logic [31:0]        mem [DEPTH_WORDS];

   req_t               cur_c;
   logic [OFS_W-1:0]   ofs_c;
   logic               err_c;
   logic [IDX_W-1:0]   idx_c;
   logic               enter_resp_c;

   // Decode the request being turned into a response: live inputs on a zero-wait accept, else the captured copy.
   // The 33-bit offset borrows into its top bit for addresses below the base, so one zero-test covers both bounds.
   always_comb begin
      cur_c = cap;
      if (state == ST_IDLE) begin
         cur_c = '{write: req_write, addr: req_addr, wdata: req_wdata};
      end
      ofs_c        = {1'b0, cur_c.addr} - {1'b0, BASE_ADDR};
      err_c        = (ofs_c[1:0] != 2'b00) || (ofs_c[OFS_W-1:IDX_W+2] != '0);
      idx_c        = ofs_c[IDX_W+1:2];
      enter_resp_c = ((state == ST_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                     ((state == ST_WAIT) && (cnt == '0));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         cnt       <= '0;
         cap       <= '0;
         for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
            mem[IDX_W'(i)] <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  cap       <= cur_c;
                  req_ready <= 1'b0;
                  state     <= ST_WAIT;
                  cnt       <= CNT_W'(WAIT_CYCLES - 1);
               end
            end
            ST_WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state     <= ST_IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
            end
         endcase

         // Memory access and response capture happen on the edge that enters RESP.
         if (enter_resp_c) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= err_c;
            rsp_rdata <= (err_c || cur_c.write) ? '0 : mem[idx_c];
            if (!err_c && cur_c.write) begin
               mem[idx_c] <= cur_c.wdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder: one instance with wait states, one with zero wait
// and a non-zero base address, both checked against an array-based memory model.
module tb_dmem_responder;

   localparam int unsigned W_A     = 2;
   localparam int unsigned DEPTH_A = 256;
   localparam logic [31:0] BASE_A  = 32'h0000_0000;
   localparam int unsigned W_B     = 0;
   localparam int unsigned DEPTH_B = 16;
   localparam logic [31:0] BASE_B  = 32'h0000_2000;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [1:0]      req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
   logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;

   exp_t        sb [2][$];
   logic [31:0] mm [2][256];
   int          cyc = 0;
   int          checks = 0;
   int          passes = 0;
   bit          armed = 1'b0;
   int          rdy_mode [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder #(.DEPTH_WORDS(DEPTH_A), .WAIT_CYCLES(W_A), .BASE_ADDR(BASE_A)) u_dut_a (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
   );

   dmem_responder #(.DEPTH_WORDS(DEPTH_B), .WAIT_CYCLES(W_B), .BASE_ADDR(BASE_B)) u_dut_b (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
   );

   function automatic int unsigned wait_of(input int d);
      return (d == 0) ? W_A : W_B;
   endfunction

   function automatic int unsigned depth_of(input int d);
      return (d == 0) ? DEPTH_A : DEPTH_B;
   endfunction

   function automatic logic [31:0] base_of(input int d);
      return (d == 0) ? BASE_A : BASE_B;
   endfunction

   // Reference behaviour: byte-address range check, then word read or write in the model array.
   function automatic exp_t model(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd);
      exp_t   e;
      longint lo, hi, av;
      int     idx;
      lo = longint'(base_of(d));
      hi = lo + 4 * longint'(depth_of(d));
      av = longint'(a);
      e.rdata = 32'h0;
      e.err   = 1'b0;
      e.due   = 0;
      if ((av % 4) != 0 || av < lo || av >= hi) begin
         e.err = 1'b1;
      end else begin
         idx = int'((av - lo) / 4);
         if (w) mm[d][idx] = wd;
         else   e.rdata    = mm[d][idx];
      end
      return e;
   endfunction

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", name, d, cyc, act, exp);
   endtask

   // Monitor: checks handshake signals every cycle, compares held responses, and scores accepted requests.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         logic busy, ev;
         exp_t e;
         if (armed) begin
            busy = (sb[d].size() > 0);
            ev   = 1'b0;
            if (busy) ev = (cyc >= sb[d][0].due);
            chk("req_ready", d, 32'(req_ready[d]), 32'(!busy));
            chk("rsp_valid", d, 32'(rsp_valid[d]), 32'(ev));
            if (rsp_valid[d] && ev) begin
               chk("rsp_rdata", d, rsp_rdata[d], sb[d][0].rdata);
               chk("rsp_err", d, 32'(rsp_err[d]), 32'(sb[d][0].err));
               if (rsp_ready[d]) void'(sb[d].pop_front());
            end
         end
         if (!reset) begin
            sb[d].delete();
         end else if (armed && req_valid[d] && req_ready[d]) begin
            e     = model(d, req_write[d], req_addr[d], req_wdata[d]);
            e.due = cyc + int'(wait_of(d)) + 1;
            sb[d].push_back(e);
         end
      end
      if (!reset) begin
         for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++) mm[d][i] = 32'h0;
         armed = 1'b1;
      end
   end

   // Response-side backpressure: 0 = always ready, 1 = random, 2 = held off.
   always @(posedge clk) begin
      #2;
      for (int d = 0; d < 2; d++) begin
         case (rdy_mode[d])
            0:       rsp_ready[d] = 1'b1;
            1:       rsp_ready[d] = 1'($urandom_range(0, 1));
            default: rsp_ready[d] = 1'b0;
         endcase
      end
   end

   // Presents a request and returns just after the edge that accepts it; req_valid is left high.
   task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd);
      int n;
      n = 0;
      req_write[d] = w;
      req_addr[d]  = a;
      req_wdata[d] = wd;
      req_valid[d] = 1'b1;
      forever begin
         @(negedge clk);
         if (req_ready[d] === 1'b1) break;
         n++;
         if (n > 100) begin
            checks++;
            $display("FAIL req_timeout dut%0d: got no req_ready in %0d cycles, expected acceptance", d, n);
            req_valid[d] = 1'b0;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int d);
      int n;
      n = 0;
      while (sb[d].size() != 0) begin
         @(posedge clk);
         n++;
         if (n > 200) begin
            checks++;
            $display("FAIL rsp_timeout dut%0d: got %0d pending responses, expected 0", d, sb[d].size());
            sb[d].delete();
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd);
      issue(d, w, a, wd);
      req_valid[d] = 1'b0;
      wait_idle(d);
   endtask

   initial begin
      int          d, r, idx;
      logic [31:0] a;
      req_valid   = '0;
      req_write   = '0;
      req_addr    = '0;
      req_wdata   = '0;
      rsp_ready   = '1;
      rdy_mode[0] = 0;
      rdy_mode[1] = 0;

      // Reset held with a request pending on both instances.
      reset     = 1'b0;
      req_valid = 2'b11;
      req_write = 2'b11;
      req_wdata[0] = 32'h1234_5678;
      repeat (3) @(posedge clk);
      #1;
      reset     = 1'b1;
      req_valid = '0;
      xact(0, 1'b0, 32'h0000_0000, 32'h0);
      xact(0, 1'b0, 32'h0000_03FC, 32'h0);

      // Store then load the same word.
      xact(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
      xact(0, 1'b0, 32'h0000_0010, 32'h0);

      // Response held off while a new request waits.
      rdy_mode[0] = 2;
      issue(0, 1'b0, 32'h0000_0010, 32'h0);
      req_addr[0] = 32'h0000_03FC;
      repeat (int'(W_A) + 6) @(posedge clk);
      #1;
      rdy_mode[0] = 0;
      issue(0, 1'b0, 32'h0000_03FC, 32'h0);
      req_valid[0] = 1'b0;
      wait_idle(0);

      // Misaligned and out-of-range accesses; word 0 is where a truncated index would land.
      xact(0, 1'b0, 32'h0000_0012, 32'h0);
      xact(0, 1'b0, 32'h0000_0400, 32'h0);
      xact(0, 1'b1, 32'h0000_0401, 32'hFFFF_FFFF);
      xact(0, 1'b1, 32'h0000_0003, 32'hFFFF_FFFF);
      xact(0, 1'b0, 32'h0000_0000, 32'h0);
      xact(0, 1'b0, 32'h0000_0010, 32'h0);

      // Zero-wait instance: stores, then back-to-back loads with req_valid held high.
      for (int i = 0; i < 4; i++) xact(1, 1'b1, BASE_B + 32'(4 * i), 32'hA000_0000 + 32'(i));
      for (int i = 0; i < 6; i++) issue(1, 1'b0, BASE_B + 32'(4 * i), 32'h0);
      req_valid[1] = 1'b0;
      wait_idle(1);
      xact(1, 1'b0, BASE_B - 32'd4, 32'h0);
      xact(1, 1'b0, BASE_B + 32'(4 * DEPTH_B), 32'h0);

      // Reset while a store sits in the wait states.
      issue(0, 1'b1, 32'h0000_0020, 32'h0000_0005);
      req_valid[0] = 1'b0;
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      xact(0, 1'b0, 32'h0000_0020, 32'h0);

      // Randomized traffic with word reuse, random backpressure and occasional bad addresses.
      for (int n = 0; n < 160; n++) begin
         d           = int'($urandom_range(0, 1));
         rdy_mode[d] = int'($urandom_range(0, 1));
         r           = int'($urandom_range(0, 7));
         idx         = int'($urandom_range(0, 7));
         case (r)
            0:       a = base_of(d) + 32'(4 * idx) + 32'($urandom_range(1, 3));
            1:       a = base_of(d) + 32'(4 * depth_of(d)) + 32'(4 * $urandom_range(0, 3));
            2:       a = base_of(d) + 32'(4 * (depth_of(d) - 1));
            default: a = base_of(d) + 32'(4 * idx);
         endcase
         xact(d, 1'($urandom_range(0, 1)), a, $urandom);
      end
      rdy_mode[0] = 0;
      rdy_mode[1] = 0;
      repeat (4) @(posedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
